// File: rtl/mem_rr_arb_if.sv
// Fabric request/response payload types and the bundled master/slave bus
// seen by the round-robin memory arbiter.

typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
} mem_req_t;

typedef struct packed {
    logic [31:0] rdata;
    logic        err;
} mem_resp_t;

interface mem_rr_arb_if #(
    parameter int N_MST = 2
);
    // Master-facing side (one lane per master)
    logic [N_MST-1:0]     mn_req_valid;
    logic [N_MST-1:0]     mn_req_ready;
    mem_req_t [N_MST-1:0] mn_req;
    logic [N_MST-1:0]     mn_resp_valid;
    logic [N_MST-1:0]     mn_resp_ready;
    mem_resp_t [N_MST-1:0] mn_resp;

    // Shared target side
    logic      sn_req_valid;
    logic      sn_req_ready;
    mem_req_t  sn_req;
    logic      sn_resp_valid;
    logic      sn_resp_ready;
    mem_resp_t sn_resp;

    // The arbiter itself: it serves the masters and drives the target
    modport slave (
        input  mn_req_valid, mn_req, mn_resp_ready,
        input  sn_req_ready, sn_resp_valid, sn_resp,
        output mn_req_ready, mn_resp_valid, mn_resp,
        output sn_req_valid, sn_req, sn_resp_ready
    );

    // The surrounding agents: requesting masters plus the target
    modport master (
        output mn_req_valid, mn_req, mn_resp_ready,
        output sn_req_ready, sn_resp_valid, sn_resp,
        input  mn_req_ready, mn_resp_valid, mn_resp,
        input  sn_req_valid, sn_req, sn_resp_ready
    );
endinterface

// File: rtl/mem_rr_arb.sv
// Round-robin arbiter sharing one memory target among N_MST masters.
// Accepted requests record their master index in an in-order ID FIFO so
// each response is steered back to its issuer.

module mem_rr_arb #(
    parameter int N_MST     = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    mem_rr_arb_if.slave                bus,
    output logic [$clog2(MAX_OUTST):0] outst_cnt,
    output logic                       err_resp_orphan
);
    localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int DEPTH = 2 ** PTR_W;

    localparam logic [SUM_W-1:0] N_L      = SUM_W'(N_MST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MST - 1);
    localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] fifo_q [DEPTH];
    logic [IDX_W-1:0] fifo_d [DEPTH];

    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic [SUM_W-1:0] cand;
    logic             room;
    logic             nonempty;
    logic [IDX_W-1:0] head;
    logic             req_vld;
    logic             resp_rdy;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Grant selection: hold the locked master, else first requester at or after rr_ptr
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (lock_vld_q) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_idx_q;
        end else begin
            // Descending scan so the nearest candidate to rr_ptr is written last
            for (int k = N_MST - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr_q} + SUM_W'(k);
                if (cand >= N_L) cand = cand - N_L;
                if (bus.mn_req_valid[cand[IDX_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand[IDX_W-1:0];
                end
            end
        end
    end

    // Request and response steering; a full FIFO blocks new grants regardless of a same-cycle pop
    always_comb begin
        room     = (cnt_q != MAX_L);
        nonempty = (cnt_q != '0);
        head     = fifo_q[rd_ptr_q];
        req_vld  = gnt_vld && room;
        resp_rdy = nonempty && bus.mn_resp_ready[head];
        push     = req_vld && bus.sn_req_ready;
        pop      = bus.sn_resp_valid && resp_rdy;

        bus.sn_req_valid = req_vld;
        bus.sn_req       = bus.mn_req[gnt_idx];
        bus.mn_req_ready = '0;
        if (req_vld && bus.sn_req_ready) bus.mn_req_ready[gnt_idx] = 1'b1;

        bus.sn_resp_ready = resp_rdy;
        bus.mn_resp_valid = '0;
        if (nonempty && bus.sn_resp_valid) bus.mn_resp_valid[head] = 1'b1;
        bus.mn_resp = {N_MST{bus.sn_resp}};
    end

    // Next-state for rotation pointer, stall lock, ID FIFO and orphan flag
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        fifo_d     = fifo_q;
        err_d      = err_q | (bus.sn_resp_valid && !nonempty);

        if (push) begin
            fifo_d[wr_ptr_q] = gnt_idx;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            rr_ptr_d         = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            lock_vld_d       = 1'b0;
        end else if (req_vld) begin
            lock_vld_d = 1'b1;
            lock_idx_d = gnt_idx;
        end

        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // ID storage needs no reset: entries are only read once cnt marks them valid
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign outst_cnt       = cnt_q;
    assign err_resp_orphan = err_q;

endmodule

// File: tb/tb_mem_rr_arb.sv
// Testbench for mem_rr_arb: fixed vectors, directed corner sequences and
// random traffic compared against a queue-based reference model.

module tb_mem_rr_arb;
    localparam int N = 2;
    localparam int M = 4;

    logic              clk;
    logic              rstn;
    logic [$clog2(M):0] outst_cnt;
    logic              err_resp_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_rr;
    bit m_lock;
    int m_lock_i;
    int m_q[$];
    bit m_err;

    mem_rr_arb_if #(.N_MST(N)) bus ();

    mem_rr_arb #(.N_MST(N), .MAX_OUTST(M)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .bus             (bus),
        .outst_cnt       (outst_cnt),
        .err_resp_orphan (err_resp_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] vld;
        logic       srdy;
        logic       rvld;
        logic [1:0] rrdy;
        logic       e_svld;
        logic [7:0] e_addr;
        logic [1:0] e_mrdy;
        logic [1:0] e_rvld;
        logic       e_srrdy;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_lock = 1'b0;
        m_lock_i = 0;
        m_q.delete();
        m_err = 1'b0;
    endtask

    task automatic drive(input logic [1:0] vld, input logic srdy, input logic rvld, input logic [1:0] rrdy);
        bus.mn_req_valid  = vld;
        bus.sn_req_ready  = srdy;
        bus.sn_resp_valid = rvld;
        bus.mn_resp_ready = rrdy;
        #2;
    endtask

    task automatic set_fixed_payload();
        for (int i = 0; i < N; i++) begin
            bus.mn_req[i].we    = 1'b0;
            bus.mn_req[i].be    = 4'hF;
            bus.mn_req[i].addr  = 32'hA0 + i;
            bus.mn_req[i].wdata = 32'h1234_0000 + i;
        end
        bus.sn_resp.rdata = 32'hCAFE_0001;
        bus.sn_resp.err   = 1'b0;
    endtask

    // Checks every output against the model for the current inputs, then clocks once
    task automatic run_cycle(input string tag);
        int  g;
        bit  hg, room, nonempty, e_sv, e_srr, push, pop, orphan;
        int  head;
        logic [1:0] e_mr, e_rv;
        hg = 1'b0;
        g  = 0;
        if (m_lock) begin
            hg = 1'b1;
            g  = m_lock_i;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!hg && bus.mn_req_valid[(m_rr + k) % N]) begin
                    hg = 1'b1;
                    g  = (m_rr + k) % N;
                end
            end
        end
        room     = (m_q.size() < M);
        nonempty = (m_q.size() != 0);
        head     = nonempty ? m_q[0] : 0;
        e_sv     = hg && room;
        e_mr     = (e_sv && bus.sn_req_ready) ? 2'(1 << g) : 2'b00;
        e_rv     = (nonempty && bus.sn_resp_valid) ? 2'(1 << head) : 2'b00;
        e_srr    = nonempty && bus.mn_resp_ready[head];
        #2;
        chk({tag, ".sn_req_valid"}, 64'(bus.sn_req_valid), 64'(e_sv));
        if (e_sv) chk({tag, ".sn_req"}, 64'(bus.sn_req.addr), 64'(bus.mn_req[g].addr));
        chk({tag, ".mn_req_ready"}, 64'(bus.mn_req_ready), 64'(e_mr));
        chk({tag, ".mn_resp_valid"}, 64'(bus.mn_resp_valid), 64'(e_rv));
        chk({tag, ".sn_resp_ready"}, 64'(bus.sn_resp_ready), 64'(e_srr));
        for (int i = 0; i < N; i++)
            chk({tag, ".mn_resp"}, 64'(bus.mn_resp[i].rdata), 64'(bus.sn_resp.rdata));
        chk({tag, ".outst_cnt"}, 64'(outst_cnt), 64'(m_q.size()));
        chk({tag, ".err"}, 64'(err_resp_orphan), 64'(m_err));
        push   = e_sv && bus.sn_req_ready;
        pop    = bus.sn_resp_valid && e_srr;
        orphan = bus.sn_resp_valid && !nonempty;
        @(posedge clk);
        #1;
        if (orphan) m_err = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(g);
            m_rr   = (g + 1) % N;
            m_lock = 1'b0;
        end else if (e_sv) begin
            m_lock   = 1'b1;
            m_lock_i = g;
        end
    endtask

    initial begin
        // vld  srdy  rvld  rrdy | svld addr  mrdy  rvld  srrdy cnt
        vecs[0] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'hA0, 2'b01, 2'b00, 1'b0, 3'd0};
        vecs[1] = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 8'hA1, 2'b10, 2'b01, 1'b1, 3'd1};
        vecs[2] = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 8'hA0, 2'b00, 2'b00, 1'b0, 3'd1};
        vecs[3] = '{2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 8'hA0, 2'b01, 2'b10, 1'b1, 3'd1};
        vecs[4] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 3'd1};
        vecs[5] = '{2'b10, 1'b1, 1'b1, 2'b01, 1'b1, 8'hA1, 2'b10, 2'b01, 1'b1, 3'd1};
        vecs[6] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 2'b00, 2'b10, 1'b1, 3'd1};
        vecs[7] = '{2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 3'd0};

        rstn = 1'b0;
        set_fixed_payload();
        bus.mn_req_valid  = '0;
        bus.mn_resp_ready = '0;
        bus.sn_req_ready  = 1'b0;
        bus.sn_resp_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset state
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        chk("rst.sn_req_valid", 64'(bus.sn_req_valid), 64'd0);
        chk("rst.sn_resp_ready", 64'(bus.sn_resp_ready), 64'd0);
        chk("rst.mn_resp_valid", 64'(bus.mn_resp_valid), 64'd0);
        chk("rst.outst_cnt", 64'(outst_cnt), 64'd0);
        chk("rst.err", 64'(err_resp_orphan), 64'd0);

        // Fixed vectors
        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].vld, vecs[v].srdy, vecs[v].rvld, vecs[v].rrdy);
            chk($sformatf("vec%0d.sn_req_valid", v), 64'(bus.sn_req_valid), 64'(vecs[v].e_svld));
            if (vecs[v].e_svld)
                chk($sformatf("vec%0d.sn_req", v), 64'(bus.sn_req.addr), 64'(vecs[v].e_addr));
            chk($sformatf("vec%0d.mn_req_ready", v), 64'(bus.mn_req_ready), 64'(vecs[v].e_mrdy));
            chk($sformatf("vec%0d.mn_resp_valid", v), 64'(bus.mn_resp_valid), 64'(vecs[v].e_rvld));
            chk($sformatf("vec%0d.sn_resp_ready", v), 64'(bus.sn_resp_ready), 64'(vecs[v].e_srrdy));
            chk($sformatf("vec%0d.outst_cnt", v), 64'(outst_cnt), 64'(vecs[v].e_cnt));
            run_cycle($sformatf("vec%0d", v));
        end

        // Stall lock: master 0 stalled 3 cycles, master 1 joins, payload must not move
        drive(2'b01, 1'b0, 1'b0, 2'b00);
        chk("lock.c0", 64'(bus.sn_req.addr), 64'h0A0);
        run_cycle("lock.c0");
        for (int c = 1; c < 3; c++) begin
            drive(2'b11, 1'b0, 1'b0, 2'b00);
            chk($sformatf("lock.c%0d", c), 64'(bus.sn_req.addr), 64'h0A0);
            run_cycle("lock.stall");
        end
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        chk("lock.hs", 64'(bus.mn_req_ready), 64'b01);
        run_cycle("lock.hs");
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        chk("lock.next_gnt", 64'(bus.sn_req.addr), 64'h0A1);
        run_cycle("lock.next");
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        chk("lock.resp0", 64'(bus.mn_resp_valid), 64'b01);
        run_cycle("lock.resp0");
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        chk("lock.resp1", 64'(bus.mn_resp_valid), 64'b10);
        run_cycle("lock.resp1");

        // Outstanding limit
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 1'b1, 1'b0, 2'b00);
            chk($sformatf("full.gnt%0d", c), 64'(bus.sn_req.addr), 64'(32'hA0 + (c % 2)));
            run_cycle("full.fill");
        end
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        chk("full.cnt", 64'(outst_cnt), 64'd4);
        chk("full.sn_req_valid", 64'(bus.sn_req_valid), 64'd0);
        chk("full.mn_req_ready", 64'(bus.mn_req_ready), 64'd0);
        run_cycle("full.block");
        for (int c = 0; c < 4; c++) begin
            drive(2'b00, 1'b0, 1'b1, 2'b11);
            chk($sformatf("full.resp%0d", c), 64'(bus.mn_resp_valid), 64'(2'b01 << (c % 2)));
            run_cycle("full.drain");
        end
        chk("full.cnt_end", 64'(outst_cnt), 64'd0);

        // Response backpressure on master 1
        drive(2'b10, 1'b1, 1'b0, 2'b00);
        run_cycle("bp.req");
        for (int c = 0; c < 2; c++) begin
            drive(2'b00, 1'b0, 1'b1, 2'b01);
            chk($sformatf("bp.sn_resp_ready%0d", c), 64'(bus.sn_resp_ready), 64'd0);
            chk($sformatf("bp.mn_resp_valid%0d", c), 64'(bus.mn_resp_valid), 64'b10);
            run_cycle("bp.hold");
        end
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        chk("bp.release", 64'(bus.sn_resp_ready), 64'd1);
        run_cycle("bp.release");

        // Simultaneous push and pop at cnt=2
        for (int c = 0; c < 2; c++) begin
            drive(2'b11, 1'b1, 1'b0, 2'b00);
            run_cycle("pp.fill");
        end
        drive(2'b01, 1'b1, 1'b1, 2'b11);
        chk("pp.cnt_before", 64'(outst_cnt), 64'd2);
        chk("pp.resp", 64'(bus.mn_resp_valid), 64'b01);
        run_cycle("pp.both");
        chk("pp.cnt_after", 64'(outst_cnt), 64'd2);
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        chk("pp.order1", 64'(bus.mn_resp_valid), 64'b10);
        run_cycle("pp.drain1");
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        chk("pp.order2", 64'(bus.mn_resp_valid), 64'b01);
        run_cycle("pp.drain2");

        // Fairness with one-cycle response turnaround (rr_ptr is 1 here)
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 1'b1, (k > 0), 2'b11);
            chk($sformatf("fair.gnt%0d", k), 64'(bus.sn_req.addr), 64'(32'hA0 + ((1 + k) % 2)));
            chk($sformatf("fair.route%0d", k), 64'(bus.mn_resp_valid),
                64'((k > 0) ? (2'b01 << (k % 2)) : 2'b00));
            chk($sformatf("fair.cnt%0d", k), 64'(outst_cnt <= 1), 64'd1);
            run_cycle("fair");
        end
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        run_cycle("fair.drain");

        // Orphan response and reset
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        chk("orph.sn_resp_ready", 64'(bus.sn_resp_ready), 64'd0);
        chk("orph.mn_resp_valid", 64'(bus.mn_resp_valid), 64'd0);
        run_cycle("orph");
        chk("orph.err_set", 64'(err_resp_orphan), 64'd1);
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        run_cycle("orph.idle");
        chk("orph.err_sticky", 64'(err_resp_orphan), 64'd1);
        drive(2'b01, 1'b1, 1'b0, 2'b00);
        run_cycle("orph.push");
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        chk("rst2.err", 64'(err_resp_orphan), 64'd0);
        chk("rst2.cnt", 64'(outst_cnt), 64'd0);
        drive(2'b11, 1'b0, 1'b0, 2'b00);
        chk("rst2.rr_ptr", 64'(bus.sn_req.addr), 64'h0A0);
        run_cycle("rst2");

        // Random traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.mn_req[i].addr  = $urandom;
                bus.mn_req[i].wdata = $urandom;
                bus.mn_req[i].we    = 1'($urandom_range(0, 1));
            end
            bus.sn_resp.rdata = $urandom;
            bus.mn_req_valid  = 2'($urandom_range(0, 3));
            bus.sn_req_ready  = 1'($urandom_range(0, 1));
            bus.mn_resp_ready = 2'($urandom_range(0, 3));
            if (m_q.size() != 0) bus.sn_resp_valid = 1'($urandom_range(0, 1));
            else                 bus.sn_resp_valid = ($urandom_range(0, 49) == 0);
            run_cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
